// File: rtl/uart_tune_ctrl.sv
// UART tuning-frame parser driving the NCO phase increment.
// Replies ACK/NAK through a single pending slot towards uart_tx.
module uart_tune_ctrl #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter logic [7:0]  ACK_BYTE       = 8'h06,
  parameter logic [7:0]  NAK_BYTE       = 8'h15,
  parameter logic [63:0] RESET_INC      = 64'h0104376A9DD10437,
  parameter logic [63:0] STEP_INC       = 64'h00045641C6E59DF0,
  parameter int unsigned TIMEOUT_CYCLES = 1360000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_dv,
  input  logic [7:0]  rx_byte,
  input  logic        tx_busy,
  output logic        tx_dv,
  output logic [7:0]  tx_byte,
  output logic [63:0] phase_inc,
  output logic        phase_inc_upd,
  output logic        frame_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMD,
    S_PAYLOAD,
    S_CHECK
  } state_t;

  localparam logic [31:0] TMAX = 32'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nx;
  logic [7:0]  cmd_q;
  logic [7:0]  chk_q;
  logic [63:0] shadow;
  logic [2:0]  cnt;
  logic [31:0] gap_cnt;
  logic        timeout;
  logic        q_ack, q_nak, err, apply;
  logic [63:0] new_inc;
  logic        pend;
  logic [7:0]  pend_byte;
  logic [31:0] wait_cnt;
  logic        can_send;
  logic [7:0]  q_byte;

  assign timeout = (state != S_IDLE) && (gap_cnt == TMAX);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (timeout) begin
      state_nx = S_IDLE;
    end else if (rx_dv) begin
      unique case (state)
        S_IDLE:
          if (rx_byte == SYNC_BYTE) state_nx = S_CMD;
        S_CMD:
          if (rx_byte == 8'h01)
            state_nx = S_PAYLOAD;
          else if (rx_byte == 8'h02 || rx_byte == 8'h03)
            state_nx = S_CHECK;
          else
            state_nx = S_IDLE;
        S_PAYLOAD:
          if (cnt == 3'd7) state_nx = S_CHECK;
        S_CHECK:
          state_nx = S_IDLE;
        default:
          state_nx = S_IDLE;
      endcase
    end
  end

  always_comb begin
    q_ack = 1'b0;
    q_nak = 1'b0;
    err   = 1'b0;
    apply = 1'b0;
    if (timeout) begin
      err = 1'b1;
    end else if (rx_dv) begin
      unique case (1'b1)
        state == S_CMD:
          if (rx_byte == 8'h00 || rx_byte > 8'h03) begin
            q_nak = 1'b1;
            err   = 1'b1;
          end
        state == S_CHECK:
          if (rx_byte == chk_q) begin
            apply = 1'b1;
            q_ack = 1'b1;
          end else begin
            q_nak = 1'b1;
            err   = 1'b1;
          end
        default: ;
      endcase
    end
  end

  always_comb begin
    unique case (cmd_q)
      8'h01:   new_inc = shadow;
      8'h02:   new_inc = phase_inc + STEP_INC;
      default: new_inc = phase_inc - STEP_INC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_q   <= 8'h00;
      chk_q   <= 8'h00;
      shadow  <= 64'h0;
      cnt     <= 3'd0;
      gap_cnt <= 32'd0;
    end else begin
      if (state == S_IDLE || rx_dv) gap_cnt <= 32'd0;
      else                          gap_cnt <= gap_cnt + 32'd1;
      if (rx_dv && !timeout) begin
        if (state == S_CMD) begin
          cmd_q <= rx_byte;
          chk_q <= rx_byte;
          cnt   <= 3'd0;
        end else if (state == S_PAYLOAD) begin
          shadow <= {shadow[55:0], rx_byte};
          chk_q  <= chk_q ^ rx_byte;
          cnt    <= cnt + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_inc     <= RESET_INC;
      phase_inc_upd <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      phase_inc_upd <= apply;
      frame_err     <= err;
      if (apply) phase_inc <= new_inc;
    end
  end

  // Blocking on tx_dv keeps the strobe a single cycle wide.
  assign can_send = !tx_busy && !tx_dv;
  assign q_byte   = q_ack ? ACK_BYTE : NAK_BYTE;

  always_ff @(posedge clk) begin
    if (reset) begin
      pend      <= 1'b0;
      pend_byte <= 8'h00;
      wait_cnt  <= 32'd0;
      tx_dv     <= 1'b0;
      tx_byte   <= 8'h00;
    end else begin
      tx_dv <= 1'b0;
      if (q_ack || q_nak) begin
        if (can_send) begin
          tx_dv   <= 1'b1;
          tx_byte <= q_byte;
          pend    <= 1'b0;
        end else begin
          pend      <= 1'b1;
          pend_byte <= q_byte;
          wait_cnt  <= 32'd0;
        end
      end else if (pend) begin
        if (can_send) begin
          tx_dv   <= 1'b1;
          tx_byte <= pend_byte;
          pend    <= 1'b0;
        end else if (wait_cnt == TMAX) begin
          pend <= 1'b0;
        end else begin
          wait_cnt <= wait_cnt + 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tune_ctrl.sv
// Randomized self-checking bench for uart_tune_ctrl.
// Expected results come from a frame-level model of the protocol.
module tb_uart_tune_ctrl;

  localparam int unsigned T = 300;
  localparam logic [63:0] RST_INC = 64'h0104376A9DD10437;
  localparam logic [63:0] STEP = 64'h00045641C6E59DF0;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        reset, rx_dv, tx_busy;
  logic [7:0]  rx_byte;
  logic        tx_dv, phase_inc_upd, frame_err;
  logic [7:0]  tx_byte;
  logic [63:0] phase_inc;

  always #5 clk = ~clk;

  uart_tune_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk),
    .reset(reset),
    .rx_dv(rx_dv),
    .rx_byte(rx_byte),
    .tx_busy(tx_busy),
    .tx_dv(tx_dv),
    .tx_byte(tx_byte),
    .phase_inc(phase_inc),
    .phase_inc_upd(phase_inc_upd),
    .frame_err(frame_err)
  );

  int n_checks = 0;
  int n_errs = 0;
  int tx_cnt = 0, upd_cnt = 0, err_cnt = 0;
  int pulse_viol = 0, stray = 0;
  logic [7:0]  last_tx = 8'h00;
  logic        p_tx = 0, p_upd = 0, p_err = 0, p_rst = 1;
  logic [63:0] p_inc = 64'h0;
  logic [63:0] model_inc;

  always @(negedge clk) begin
    if (tx_dv === 1'b1) begin
      tx_cnt++;
      last_tx = tx_byte;
    end
    if (phase_inc_upd === 1'b1) upd_cnt++;
    if (frame_err === 1'b1) err_cnt++;
    if ((tx_dv & p_tx) | (phase_inc_upd & p_upd) | (frame_err & p_err))
      pulse_viol++;
    if (!p_rst && phase_inc !== p_inc && phase_inc_upd !== 1'b1)
      stray++;
    p_tx  = tx_dv;
    p_upd = phase_inc_upd;
    p_err = frame_err;
    p_rst = reset;
    p_inc = phase_inc;
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte = b;
    rx_dv = 1'b1;
    tick();
    rx_dv = 1'b0;
  endtask

  task automatic send_q(input bq_t q, input int maxgap);
    foreach (q[i]) begin
      send_byte(q[i]);
      if (i != q.size() - 1 && maxgap > 0)
        idle($urandom_range(0, maxgap));
    end
  endtask

  function automatic bool_known(input logic [7:0] c);
    return (c >= 8'h01 && c <= 8'h03);
  endfunction

  function automatic bq_t build(input logic [7:0] cmd,
                                input logic [63:0] pay,
                                input logic [7:0] flip);
    bq_t q;
    logic [7:0] x, b;
    q = {8'hA5, cmd};
    x = cmd;
    if (cmd == 8'h01)
      for (int i = 0; i < 8; i++) begin
        b = pay[63-8*i -: 8];
        q.push_back(b);
        x ^= b;
      end
    if (bool_known(cmd)) q.push_back(x ^ flip);
    return q;
  endfunction

  task automatic run_frame(input logic [7:0] cmd, input logic [63:0] pay,
                           input logic [7:0] flip, input int maxgap);
    int t0, u0, e0;
    bit good;
    t0 = tx_cnt;
    u0 = upd_cnt;
    e0 = err_cnt;
    good = bool_known(cmd) && flip == 8'h00;
    if (good)
      case (cmd)
        8'h01:   model_inc = pay;
        8'h02:   model_inc = model_inc + STEP;
        default: model_inc = model_inc - STEP;
      endcase
    send_q(build(cmd, pay, flip), maxgap);
    idle(3);
    check("inc", phase_inc, model_inc);
    check("upd_n", 64'(upd_cnt - u0), good ? 64'd1 : 64'd0);
    check("err_n", 64'(err_cnt - e0), good ? 64'd0 : 64'd1);
    check("tx_n", 64'(tx_cnt - t0), 64'd1);
    check("tx_byte", last_tx, good ? ACK : NAK);
  endtask

  initial begin
    int t0, u0, e0;
    logic [7:0] c, f;
    logic [63:0] p;
    reset = 1'b1;
    rx_dv = 1'b0;
    rx_byte = 8'h00;
    tx_busy = 1'b0;
    idle(3);
    reset = 1'b0;
    check("rst_inc", phase_inc, RST_INC);
    check("rst_tx_dv", tx_dv, 0);
    check("rst_tx_byte", tx_byte, 0);
    check("rst_upd", phase_inc_upd, 0);
    check("rst_err", frame_err, 0);
    model_inc = RST_INC;
    idle(2);

    send_q(build(8'h01, 64'h0104376A9DD10437, 8'h00), 0);
    check("t1_inc", phase_inc, 64'h0104376A9DD10437);
    check("t1_upd", phase_inc_upd, 1);
    check("t1_tx_dv", tx_dv, 1);
    check("t1_tx_byte", tx_byte, ACK);
    tick();
    check("t1_upd_off", phase_inc_upd, 0);
    check("t1_tx_off", tx_dv, 0);
    idle(3);

    run_frame(8'h01, 64'h0104376A9DD10437, 8'h01, 0);
    check("t2_inc", phase_inc, RST_INC);

    run_frame(8'h01, 64'hFFFFFFFFFFFFFFFF, 8'h00, 2);
    run_frame(8'h02, 64'h0, 8'h00, 2);
    check("t3_wrap_up", phase_inc, 64'h00045641C6E59DEF);
    run_frame(8'h03, 64'h0, 8'h00, 2);
    check("t3_wrap_dn", phase_inc, 64'hFFFFFFFFFFFFFFFF);

    t0 = tx_cnt; u0 = upd_cnt; e0 = err_cnt;
    send_q({8'hA5, 8'h01, 8'h12, 8'h34}, 0);
    idle(T + 10);
    check("t4_err_n", 64'(err_cnt - e0), 1);
    check("t4_tx_n", 64'(tx_cnt - t0), 0);
    check("t4_upd_n", 64'(upd_cnt - u0), 0);
    check("t4_inc", phase_inc, model_inc);
    run_frame(8'h02, 64'h0, 8'h00, 1);

    t0 = tx_cnt; e0 = err_cnt;
    send_byte(8'hA5);
    send_byte(8'h02);
    idle(T - 5);
    send_byte(8'h02);
    model_inc = model_inc + STEP;
    idle(3);
    check("gap_inc", phase_inc, model_inc);
    check("gap_err_n", 64'(err_cnt - e0), 0);
    check("gap_tx", last_tx, ACK);

    tx_busy = 1'b1;
    t0 = tx_cnt;
    send_q(build(8'h03, 64'h0, 8'h00), 0);
    model_inc = model_inc - STEP;
    idle(100);
    check("t5_held", 64'(tx_cnt - t0), 0);
    check("t5_inc", phase_inc, model_inc);
    tx_busy = 1'b0;
    tick();
    check("t5_tx_dv", tx_dv, 1);
    check("t5_tx_byte", tx_byte, ACK);
    tick();
    check("t5_tx_off", tx_dv, 0);

    tx_busy = 1'b1;
    t0 = tx_cnt;
    send_q(build(8'h02, 64'h0, 8'h00), 0);
    model_inc = model_inc + STEP;
    idle(T + 20);
    tx_busy = 1'b0;
    idle(10);
    check("t5_drop", 64'(tx_cnt - t0), 0);
    check("t5_drop_inc", phase_inc, model_inc);

    tx_busy = 1'b1;
    t0 = tx_cnt;
    send_q(build(8'h02, 64'h0, 8'h00), 0);
    idle(2);
    send_q({8'hA5, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55}, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_inc = RST_INC;
    check("t6_inc", phase_inc, RST_INC);
    check("t6_tx_byte", tx_byte, 0);
    tx_busy = 1'b0;
    idle(10);
    check("t6_no_reply", 64'(tx_cnt - t0), 0);
    send_byte(8'hA5);
    send_byte(8'h7E);
    check("t6_unk_err", frame_err, 1);
    check("t6_unk_tx", tx_dv, 1);
    check("t6_unk_byte", tx_byte, NAK);
    send_byte(8'h7E);
    idle(3);
    run_frame(8'h01, 64'h0123456789ABCDEF, 8'h00, 1);

    for (int n = 0; n < 40; n++) begin
      int r;
      r = $urandom_range(0, 7);
      if (r < 3)      c = 8'h01;
      else if (r < 5) c = 8'h02;
      else if (r < 6) c = 8'h03;
      else if (r < 7) c = 8'hA5;
      else            c = 8'($urandom_range(4, 255));
      f = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      p = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) p[39:32] = 8'hA5;
      repeat ($urandom_range(0, 2)) begin
        logic [7:0] z;
        z = 8'($urandom_range(0, 255));
        if (z == 8'hA5) z = 8'h5A;
        send_byte(z);
        idle($urandom_range(0, 2));
      end
      run_frame(c, p, f, 3);
    end

    check("pulse_width", 64'(pulse_viol), 0);
    check("stray_change", 64'(stray), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
